bitfusion_seq_mult: RTL

- Sequential fused-precision multiplier for the sparse DNN datapath.
- Splits WIDTH-bit activation and weight operands into 2-bit slices, feeds one slice pair per cycle to a single 2-bit signed/unsigned brick multiplier, and recomposes the shifted partial products into the full product.
- Takes operands from the PE front end with a valid/ready handshake and returns the product downstream with another valid/ready handshake.

---
 rtl/bitfusion_pkg.sv | 19 +
 rtl/bitbrick_sx.sv | 21 ++
 rtl/bitfusion_seq_mult.sv | 119 +++++++++++
 3 files changed

// File: rtl/bitfusion_pkg.sv
// Shared types and helpers for the bit-fusion sequential multiplier.
package bitfusion_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned SLICE_W  = 2;
    localparam int unsigned BRICK_PW = 5;

    // Only the top slice of an operand carries its sign; lower slices are magnitude bits.
    function automatic logic slice_signed(input int unsigned idx, input int unsigned n,
                                          input logic flag);
        return flag && (idx == n - 1);
    endfunction

endpackage

// File: rtl/bitbrick_sx.sv
// 2x2 bit-brick multiplier with independent signed/unsigned operand modes.
module bitbrick_sx
    import bitfusion_pkg::*;
(
    input  logic        [SLICE_W-1:0]  a,
    input  logic        [SLICE_W-1:0]  w,
    input  logic                       a_sgn,
    input  logic                       w_sgn,
    output logic signed [BRICK_PW-1:0] pp
);

    logic signed [SLICE_W:0] ax;
    logic signed [SLICE_W:0] wx;

    always_comb begin
        ax = {a_sgn & a[SLICE_W-1], a};
        wx = {w_sgn & w[SLICE_W-1], w};
        pp = BRICK_PW'(ax) * BRICK_PW'(wx);
    end

endmodule

// File: rtl/bitfusion_seq_mult.sv
// Sequential fused-precision multiplier: one 2-bit slice pair per cycle through a
// single bit-brick, shifted partial products accumulated into a 2*WIDTH product.
module bitfusion_seq_mult
    import bitfusion_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   w,
    input  logic               a_signed,
    input  logic               w_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned N     = WIDTH / 2;
    localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned SH_W  = $clog2(ACC_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state, state_nxt;

    logic [CW-1:0]             i, j;
    logic [WIDTH-1:0]          a_q, w_q;
    logic                      as_q, ws_q;
    logic [ACC_W-1:0]          acc, acc_nxt;
    logic [SLICE_W-1:0]        a_sl, w_sl;
    logic                      a_sl_sgn, w_sl_sgn;
    logic signed [BRICK_PW-1:0] pp;
    logic [SH_W-1:0]           shamt;
    logic                      accept, last;

    always_comb begin
        a_sl     = a_q[{i, 1'b0} +: SLICE_W];
        w_sl     = w_q[{j, 1'b0} +: SLICE_W];
        a_sl_sgn = slice_signed(32'(i), N, as_q);
        w_sl_sgn = slice_signed(32'(j), N, ws_q);
    end

    bitbrick_sx u_brick (
        .a     (a_sl),
        .w     (w_sl),
        .a_sgn (a_sl_sgn),
        .w_sgn (w_sl_sgn),
        .pp    (pp)
    );

    always_comb begin
        shamt   = (SH_W'(i) + SH_W'(j)) << 1;
        acc_nxt = acc + (ACC_W'(pp) << shamt);
        accept  = (state == IDLE) && in_valid;
        last    = (state == RUN) && (i == LAST) && (j == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            w_q  <= '0;
            as_q <= 1'b0;
            ws_q <= 1'b0;
            acc  <= '0;
            i    <= '0;
            j    <= '0;
            p    <= '0;
        end else if (accept) begin
            a_q  <= a;
            w_q  <= w;
            as_q <= a_signed;
            ws_q <= w_signed;
            acc  <= '0;
            i    <= '0;
            j    <= '0;
        end else if (state == RUN) begin
            acc <= acc_nxt;
            if (j == LAST) begin
                j <= '0;
                i <= last ? '0 : i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
            if (last) p <= acc_nxt;
        end
    end

endmodule
